fifo_input_control_unit: RTL
============================

Name: fifo_input_control_unit

Overview:
Write-side control stage of the 32-entry byte FIFO. It sits directly upstream of the FIFO storage and the read-side output control stage. It accepts producer writes and issues the storage write strobe, address and data. It tracks occupancy using the read-side pop pulse, and flags full, almost-full and overflow conditions. Because the read side treats a 0x00 byte as "no data", this block never writes 0x00 into storage.

Parameters:
DEPTH, 32, number of FIFO entries; must be a power of two
PTR_W, 5, pointer width; log2(DEPTH)
DATA_W, 8, data width
AFULL_THRESH, 28, occupancy at or above which almost_full asserts

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
write_en  input  1  producer write request, sampled each cycle
data_in  input  DATA_W  producer data
rd_pop  input  1  one-cycle pulse from the read-side stage for each successful read (its read_en_o)
clear_ovf  input  1  clears overflow_sticky
write_en_o  output  1  storage write strobe, registered
wr_ptr  output  PTR_W  storage write address, valid while write_en_o=1
wr_data  output  DATA_W  storage write data, valid while write_en_o=1
count  output  PTR_W+1  current occupancy, 0..DEPTH
full  output  1  count==DEPTH
almost_full  output  1  count>=AFULL_THRESH
overflow  output  1  one-cycle pulse: a write was rejected because the FIFO was full
overflow_sticky  output  1  latched overflow, held until clear_ovf or reset
zero_drop  output  1  one-cycle pulse: a write was rejected because data_in==0

Behaviour:
- Reset (clk edge with reset=1):
  - All outputs 0; internal next-address register = 0; state = EMPTY.
  - reset has priority over every other input; reset mid-burst discards occupancy immediately.
- Latency: all outputs registered. A write sampled at edge N appears on write_en_o/wr_ptr/wr_data during cycle N+1 (one pulse per accepted write).
- Acceptance at each edge, with write_en=1:
  - data_in==0: reject. zero_drop=1, no pointer/count change. This check takes precedence over the full check.
  - else if count<DEPTH, or rd_pop=1 in the same cycle: accept. write_en_o=1, wr_ptr=next address, wr_data=data_in; next address increments modulo DEPTH (31 -> 0 wrap).
  - else: reject. overflow=1, overflow_sticky=1.
- write_en=0: write_en_o=0; overflow and zero_drop are 0 in every non-reject cycle.
- Occupancy update per edge:
  - accept && !rd_pop: +1
  - !accept && rd_pop && count>0: -1
  - accept && rd_pop: unchanged
  - rd_pop with count==0: ignored; count never underflows.
- overflow_sticky:
  - clear_ovf=1 clears it.
  - If clear_ovf and a new overflow occur in the same cycle, the set wins (stays 1).
- State machine, tracked from the next count:
  - EMPTY (count==0): accept -> ACTIVE
  - ACTIVE (0<count<DEPTH): count reaches DEPTH -> FULL; count reaches 0 -> EMPTY
  - FULL (count==DEPTH): rd_pop without write -> ACTIVE; simultaneous write+rd_pop stays FULL
- full and almost_full are registered from the next count, so they are coincident with count.
- The block holds no read pointer; the read-side stage owns it.

Test Plan:
- Reset, then write 0x11,0x22,0x33 on consecutive cycles -> write_en_o pulses with wr_ptr 0,1,2 and wr_data 0x11,0x22,0x33 one cycle after each; count 1,2,3; full=0.
- Write 32 nonzero bytes with no pops -> almost_full rises when count=28; full=1 at count=32. A 33rd write -> overflow pulse, overflow_sticky=1, no write_en_o, count stays 32.
- At full, write 0x5A together with rd_pop -> accepted at wr_ptr=0 (wrapped); count stays 32, full stays 1, no overflow.
- Write data_in=0x00 in EMPTY -> zero_drop=1, write_en_o=0, count=0, wr_ptr next still 0.
- With count=0, pulse rd_pop ×3 -> count stays 0. Then 5 writes with pops on alternate cycles -> count ends at 3 (5 writes − 2 pops).
- With overflow_sticky=1, assert clear_ovf alone -> 0. Then assert clear_ovf with a simultaneous rejected full write -> stays 1. Reset mid-burst at count=17 -> count=0 and all flags 0 the next cycle.

Source files
------------

// File: rtl/fifo_input_control_unit.sv
// ---------------------------------------------------------------------------
// fifo_input_control_unit
//
// Write-side control stage of the byte FIFO. It accepts producer writes and
// issues the registered storage write strobe, address and data. It tracks
// occupancy using the read-side pop pulse, and flags full, almost-full and
// overflow. A 0x00 byte is never written, because the read side treats 0x00
// as "no data".
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-high reset (highest priority)
//   write_en        producer write request, sampled each cycle
//   data_in         producer data
//   rd_pop          one-cycle pulse per successful read-side read
//   clear_ovf       clears overflow_sticky
//   write_en_o      storage write strobe (one pulse per accepted write)
//   wr_ptr          storage write address, valid while write_en_o=1
//   wr_data         storage write data, valid while write_en_o=1
//   count           occupancy, 0..DEPTH
//   full            count == DEPTH
//   almost_full     count >= AFULL_THRESH
//   overflow        pulse: write rejected because the FIFO was full
//   overflow_sticky latched overflow, held until clear_ovf or reset
//   zero_drop       pulse: write rejected because data_in == 0
// ---------------------------------------------------------------------------
module fifo_input_control_unit #(
    parameter int DEPTH        = 32,
    parameter int PTR_W        = 5,
    parameter int DATA_W       = 8,
    parameter int AFULL_THRESH = 28
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_pop,
    input  logic              clear_ovf,
    output logic              write_en_o,
    output logic [PTR_W-1:0]  wr_ptr,
    output logic [DATA_W-1:0] wr_data,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              almost_full,
    output logic              overflow,
    output logic              overflow_sticky,
    output logic              zero_drop
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] AFULL_C = (PTR_W+1)'(AFULL_THRESH);

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_ACTIVE = 2'd1,
        S_FULL   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  next_addr_q, next_addr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              we_q, we_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              full_q, full_d;
    logic              afull_q, afull_d;
    logic              ovf_q, ovf_d;
    logic              sticky_q, sticky_d;
    logic              zdrop_q, zdrop_d;

    logic              data_zero;
    logic              room;
    logic              accept;
    logic              reject_full;
    logic              reject_zero;

    // Acceptance decision. The zero-data check comes first so a 0x00 byte
    // presented while full reports zero_drop, not overflow. A pop in the same
    // cycle frees a slot, so a full FIFO can still take a write.
    always_comb begin
        data_zero   = (data_in == '0);
        room        = (count_q < DEPTH_C) || rd_pop;
        reject_zero = write_en && data_zero;
        accept      = write_en && !data_zero && room;
        reject_full = write_en && !data_zero && !room;
    end

    // Datapath next-state: write strobe/address/data, occupancy, flags.
    always_comb begin
        next_addr_d = next_addr_q;
        count_d     = count_q;
        we_d        = 1'b0;
        ptr_d       = ptr_q;
        data_d      = data_q;
        ovf_d       = reject_full;
        zdrop_d     = reject_zero;
        sticky_d    = sticky_q;

        if (accept) begin
            we_d        = 1'b1;
            ptr_d       = next_addr_q;
            data_d      = data_in;
            next_addr_d = next_addr_q + 1'b1;   // wraps modulo DEPTH
        end

        if (accept && !rd_pop) begin
            count_d = count_q + 1'b1;
        end else if (!accept && rd_pop && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end

        // A new overflow wins over a simultaneous clear.
        if (reject_full) begin
            sticky_d = 1'b1;
        end else if (clear_ovf) begin
            sticky_d = 1'b0;
        end
    end

    // Occupancy state machine, tracked from the next count so that full
    // is coincident with count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: begin
                if (count_d == DEPTH_C) begin
                    state_d = S_FULL;
                end else if (count_d != '0) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (count_d == DEPTH_C) begin
                    state_d = S_FULL;
                end else if (count_d == '0) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (count_d == '0) begin
                    state_d = S_EMPTY;
                end else if (count_d != DEPTH_C) begin
                    state_d = S_ACTIVE;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase

        full_d  = (state_d == S_FULL);
        afull_d = (count_d >= AFULL_C);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_EMPTY;
            next_addr_q <= '0;
            count_q     <= '0;
            we_q        <= 1'b0;
            ptr_q       <= '0;
            data_q      <= '0;
            full_q      <= 1'b0;
            afull_q     <= 1'b0;
            ovf_q       <= 1'b0;
            sticky_q    <= 1'b0;
            zdrop_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            count_q     <= count_d;
            we_q        <= we_d;
            ptr_q       <= ptr_d;
            data_q      <= data_d;
            full_q      <= full_d;
            afull_q     <= afull_d;
            ovf_q       <= ovf_d;
            sticky_q    <= sticky_d;
            zdrop_q     <= zdrop_d;
        end
    end

    assign write_en_o      = we_q;
    assign wr_ptr          = ptr_q;
    assign wr_data         = data_q;
    assign count           = count_q;
    assign full            = full_q;
    assign almost_full     = afull_q;
    assign overflow        = ovf_q;
    assign overflow_sticky = sticky_q;
    assign zero_drop       = zdrop_q;

endmodule
